// File: rtl/cond_logic_unit.sv
// Condition-check and flag-register unit for the single-cycle ARM datapath.
// Holds NZCV, evaluates the instruction's Cond field, gates write strobes and counts executed/skipped instructions.
module cond_logic_unit #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    output logic             CondEx,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_count,
    output logic [CNT_W-1:0] skip_count
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    logic [3:0]       r_flags;
    logic [CNT_W-1:0] r_exec_count;
    logic [CNT_W-1:0] r_skip_count;

    logic  w_n, w_z, w_c, w_v;
    logic  w_cond_ex;
    cond_e w_cond;

    assign w_cond = cond_e'(Cond);
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Evaluated only against the registered flags, never against this instruction's ALUFlags.
    always_comb begin
        w_cond_ex = 1'b0;
        case (w_cond)
            COND_EQ: w_cond_ex = w_z;
            COND_NE: w_cond_ex = ~w_z;
            COND_CS: w_cond_ex = w_c;
            COND_CC: w_cond_ex = ~w_c;
            COND_MI: w_cond_ex = w_n;
            COND_PL: w_cond_ex = ~w_n;
            COND_VS: w_cond_ex = w_v;
            COND_VC: w_cond_ex = ~w_v;
            COND_HI: w_cond_ex = w_c & ~w_z;
            COND_LS: w_cond_ex = ~w_c | w_z;
            COND_GE: w_cond_ex = (w_n == w_v);
            COND_LT: w_cond_ex = (w_n != w_v);
            COND_GT: w_cond_ex = ~w_z & (w_n == w_v);
            COND_LE: w_cond_ex = w_z | (w_n != w_v);
            COND_AL: w_cond_ex = 1'b1;
            COND_NV: w_cond_ex = 1'b0;
            default: w_cond_ex = 1'b0;
        endcase
    end

    assign CondEx   = w_cond_ex;
    assign PCSrc    = PCS  & w_cond_ex & en;
    assign RegWrite = RegW & w_cond_ex & en;
    assign MemWrite = MemW & w_cond_ex & en;

    // Each flag half is written only when its FlagW bit is set, so X on unused ALUFlags never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= '0;
        end else if (en && w_cond_ex) begin
            if (FlagW[1]) begin
                r_flags[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                r_flags[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_count <= '0;
            r_skip_count <= '0;
        end else if (en) begin
            if (w_cond_ex) begin
                if (r_exec_count != '1) begin
                    r_exec_count <= r_exec_count + 1'b1;
                end
            end else begin
                if (r_skip_count != '1) begin
                    r_skip_count <= r_skip_count + 1'b1;
                end
            end
        end
    end

    assign Flags      = r_flags;
    assign exec_count = r_exec_count;
    assign skip_count = r_skip_count;

endmodule

// File: tb/tb_cond_logic_unit.sv
// Self-checking bench for cond_logic_unit: directed cases plus randomized traffic against a reference model.
module tb_cond_logic_unit;

    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             en;
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             CondEx;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] exec_count;
    logic [CNT_W-1:0] skip_count;

    cond_logic_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .MemW       (MemW),
        .CondEx     (CondEx),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Flags      (Flags),
        .exec_count (exec_count),
        .skip_count (skip_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    int m_n, m_z, m_c, m_v;
    int m_exec, m_skip;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ARM encoding: Cond[3:1] picks a predicate, Cond[0] inverts it; 1111 never passes.
    function automatic int cond_pass(input int c);
        int base;
        case (c / 2)
            0: base = m_z;
            1: base = m_c;
            2: base = m_n;
            3: base = m_v;
            4: base = (m_c == 1 && m_z == 0) ? 1 : 0;
            5: base = (m_n == m_v) ? 1 : 0;
            6: base = (m_z == 0 && m_n == m_v) ? 1 : 0;
            default: base = 1;
        endcase
        if (c == 15) return 0;
        if (c == 14) return 1;
        return (c % 2 == 1) ? 1 - base : base;
    endfunction

    function automatic int model_flags();
        return m_n * 8 + m_z * 4 + m_c * 2 + m_v;
    endfunction

    // Applies one instruction: checks combinational outputs, clocks it, checks registered state.
    task automatic cycle(input int rst, input int e, input int c, input int af,
                         input int fw, input int pcs, input int rw, input int mw);
        int ce;
        reset    = rst[0];
        en       = e[0];
        Cond     = c[3:0];
        ALUFlags = af[3:0];
        FlagW    = fw[1:0];
        PCS      = pcs[0];
        RegW     = rw[0];
        MemW     = mw[0];
        #1;
        ce = cond_pass(c);
        check("CondEx",   int'(CondEx),   ce);
        check("PCSrc",    int'(PCSrc),    pcs & ce & e);
        check("RegWrite", int'(RegWrite), rw & ce & e);
        check("MemWrite", int'(MemWrite), mw & ce & e);
        @(posedge clk);
        if (rst != 0) begin
            m_n = 0; m_z = 0; m_c = 0; m_v = 0;
            m_exec = 0; m_skip = 0;
        end else if (e != 0) begin
            if (ce != 0) begin
                if ((fw / 2) % 2 == 1) begin
                    m_n = (af / 8) % 2;
                    m_z = (af / 4) % 2;
                end
                if (fw % 2 == 1) begin
                    m_c = (af / 2) % 2;
                    m_v = af % 2;
                end
                m_exec = (m_exec + 1 > CNT_MAX) ? CNT_MAX : m_exec + 1;
            end else begin
                m_skip = (m_skip + 1 > CNT_MAX) ? CNT_MAX : m_skip + 1;
            end
        end
        #1;
        check("Flags",      int'(Flags),      model_flags());
        check("exec_count", int'(exec_count), m_exec);
        check("skip_count", int'(skip_count), m_skip);
        @(negedge clk);
    endtask

    initial begin
        m_n = 0; m_z = 0; m_c = 0; m_v = 0;
        m_exec = 0; m_skip = 0;
        reset = 1'b1; en = 1'b0; Cond = 4'hE; ALUFlags = '0; FlagW = '0;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        @(negedge clk);

        // Reset, then AL passes and EQ fails with Z=0
        cycle(1, 1, 14, 0, 0, 0, 0, 0);
        check("reset_flags", int'(Flags), 0);
        cycle(0, 1, 14, 0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0, 1, 1, 1);

        // SUBS-style flag set then EQ / HI
        cycle(0, 1, 14, 4'b0110, 3, 0, 0, 0);
        check("subs_flags", int'(Flags), 4'b0110);
        cycle(0, 1, 0, 0, 0, 0, 1, 0);
        cycle(0, 1, 8, 0, 0, 0, 1, 0);

        // Independent flag halves
        cycle(0, 1, 14, 4'b1111, 3, 0, 0, 0);
        cycle(0, 1, 14, 4'b0000, 2, 0, 0, 0);
        check("partial_nz", int'(Flags), 4'b0011);
        cycle(0, 1, 14, 4'b0000, 1, 0, 0, 0);
        check("partial_cv", int'(Flags), 4'b0000);

        // Failed condition must not write flags
        cycle(0, 1, 0, 4'b1111, 3, 1, 1, 1);
        check("nowrite_flags", int'(Flags), 0);

        // Stall then release
        cycle(0, 0, 14, 4'b1001, 3, 1, 1, 1);
        cycle(0, 1, 14, 4'b1001, 3, 1, 1, 1);
        check("release_flags", int'(Flags), 4'b1001);

        // Full condition sweep: load each flag value, then evaluate all codes while stalled
        for (int f = 0; f < 16; f++) begin
            cycle(0, 1, 14, f, 3, 0, 0, 0);
            for (int c = 0; c < 16; c++) begin
                cycle(0, 0, c, $urandom_range(0, 15), 3, 1, 1, 1);
            end
        end

        // Counter saturation
        cycle(1, 1, 14, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle(0, 1, 14, 0, 0, 0, 0, 0);
        check("exec_sat", int'(exec_count), CNT_MAX);
        for (int i = 0; i < 20; i++) cycle(0, 1, 15, 0, 0, 0, 0, 0);
        check("skip_sat", int'(skip_count), CNT_MAX);

        // Reset wins over a flag-setting instruction
        cycle(1, 1, 14, 4'b1111, 3, 0, 0, 0);
        check("reset_mid", int'(Flags), 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 39) == 0) ? 1 : 0,
                  ($urandom_range(0, 4) != 0) ? 1 : 0,
                  $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_logic_unit.md
Name: cond_logic_unit

Overview:
- Sits directly downstream of the ALU decoder in the single-cycle ARM datapath. It consumes FlagW, the ALU's NZCV result flags and the instruction's Cond field.
- Holds the architectural NZCV flag register and evaluates the 16 ARM condition codes against it.
- Gates the PC-source, register-write and memory-write strobes so that instructions failing their condition have no side effects.
- Provides saturating executed/skipped instruction counters for debug.

Parameters:
- CNT_W, 16, width of the executed and skipped counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  instruction-valid / not-stalled; 0 freezes all state and suppresses all write strobes.
- Cond  input  4  instruction bits [31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  [1] = update N,Z; [0] = update C,V (from ALU decoder).
- PCS  input  1  instruction writes the PC (branch or Rd=15).
- RegW  input  1  instruction writes the register file.
- MemW  input  1  instruction writes data memory.
- CondEx  output  1  current condition passes.
- PCSrc  output  1  PCS & CondEx & en.
- RegWrite  output  1  RegW & CondEx & en.
- MemWrite  output  1  MemW & CondEx & en.
- Flags  output  4  registered {N,Z,C,V}.
- exec_count  output  CNT_W  count of cycles with en=1 and CondEx=1.
- skip_count  output  CNT_W  count of cycles with en=1 and CondEx=0.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - Flags=4'b0000, exec_count=0, skip_count=0.
  - reset has priority over en and over any flag write in the same cycle.
- CondEx is combinational from Cond and the registered Flags; it is never evaluated against ALUFlags of the same instruction. Condition table (N,Z,C,V = Flags[3:0]):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z & (N==V)
  - 1101 LE: Z | (N!=V)
  - 1110 AL: 1
  - 1111: 0 (unsupported/never; no side effects)
- Output gating:
  - PCSrc, RegWrite and MemWrite are pure combinational AND terms as listed under Ports.
  - The write strobes are 0 whenever en=0, regardless of CondEx.
- Flag update at the rising edge, when reset=0, en=1 and CondEx=1:
  - FlagW[1]=1: Flags[3:2] <= ALUFlags[3:2].
  - FlagW[0]=1: Flags[1:0] <= ALUFlags[1:0].
  - The two halves update independently, e.g. FlagW=2'b10 updates N,Z and holds C,V.
  - If CondEx=0 or en=0, Flags hold.
  - The new flags are visible to CondEx in the next cycle only (one-cycle latency). A flag-setting instruction cannot affect its own condition.
- Counters:
  - On each edge with en=1, exactly one counter increments: exec_count if CondEx=1, skip_count otherwise.
  - Both saturate at 2^CNT_W-1 and never wrap.
  - en=0: both hold.
- X handling:
  - ALUControl undefined codes upstream may drive X on ALUFlags. Flags must not change when the corresponding FlagW bit is 0.
  - FlagW is only consulted when CondEx=1.
- Reset asserted while a flag-setting instruction is presented: reset wins, Flags=0000 next cycle.

Test Plan:
- Reset then hold Cond=1110, en=1 -> Flags=0000, CondEx=1; with RegW=1, RegWrite=1. Cond=0000 (EQ) -> CondEx=0, RegWrite=0, MemWrite=0, PCSrc=0.
- SUBS sequence: Cond=1110, FlagW=11, ALUFlags=0110 -> next cycle Flags=0110. Then Cond=0000 (EQ) -> CondEx=1; Cond=1000 (HI) -> CondEx=0 (C=1, Z=1).
- Partial write: Flags=1111, then FlagW=10, ALUFlags=0000, Cond=1110 -> Flags=0011. Then FlagW=01, ALUFlags=0000 -> Flags=0000.
- Failed condition suppresses flag write: Flags=0000, Cond=0000 (EQ fails), FlagW=11, ALUFlags=1111 -> Flags stays 0000, skip_count +1, exec_count unchanged.
- Stall: en=0, Cond=1110, FlagW=11, ALUFlags=1001, PCS=RegW=MemW=1 -> all strobes 0, Flags and counters unchanged. Release en -> strobes 1, Flags=1001 next cycle.
- Sweep all 16 Cond values against all 16 Flags values -> CondEx matches the table, Cond=1111 always 0. With CNT_W=4, 20 AL cycles -> exec_count saturates at 15. Reset mid-sequence -> counters 0, Flags 0000.
